// File: rtl/mdu_beta.sv
// mdu_beta: multi-cycle multiply/divide unit with architectural HI/LO.
// Multiply results wait out MUL_LAT cycles on a down-counter. Divides run a
// restoring divider on operand magnitudes, one quotient bit per cycle, and
// then spend one cycle fixing up the signs.
// Optional feature: define MDU_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 7-10). Without it those ops are illegal and no accumulator adder exists.
module mdu_beta #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             err_op
);

    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic              accept, commit;
    logic              op_mul, op_acc, op_div, op_mthi, op_mtlo, op_illegal, op_signed;

    logic [2*WIDTH-1:0] ext_a, ext_b, product, prod, mul_result;
    logic              sign_a, sign_b;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH-1:0]  rem, quot, dvsr, raw_a;
    logic              neg_q, neg_r, div_zero;
    logic [WIDTH:0]    rem_sh, diff;
`ifdef MDU_ACCUM_EN
    logic              acc_en, acc_sub;
`endif

    // Sort the incoming opcode into the classes the control logic cares about
    always_comb begin
        op_mul     = 1'b0;
        op_acc     = 1'b0;
        op_div     = 1'b0;
        op_mthi    = 1'b0;
        op_mtlo    = 1'b0;
        op_illegal = 1'b0;
        case (req_op)
            4'd0: begin end
            4'd1, 4'd2: op_mul = 1'b1;
            4'd3, 4'd4: op_div = 1'b1;
            4'd5: op_mthi = 1'b1;
            4'd6: op_mtlo = 1'b1;
`ifdef MDU_ACCUM_EN
            4'd7, 4'd8, 4'd9, 4'd10: op_acc = 1'b1;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    // Odd opcodes among the arithmetic ops are the signed variants
    assign op_signed = req_op[0];

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign commit    = busy & ~flush & (count == '0);

    // Full-width product: sign- or zero-extend, then keep the low 2*WIDTH bits
    assign ext_a   = op_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    assign ext_b   = op_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    assign product = ext_a * ext_b;

    // Divider operates on magnitudes; signs are reapplied at commit
    assign sign_a = op_signed & src_a[WIDTH-1];
    assign sign_b = op_signed & src_b[WIDTH-1];
    assign mag_a  = sign_a ? -src_a : src_a;
    assign mag_b  = sign_b ? -src_b : src_b;

    assign rem_sh = {rem, quot[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvsr};

`ifdef MDU_ACCUM_EN
    assign mul_result = !acc_en ? prod :
                        acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
`else
    assign mul_result = prod;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: leave IDLE on a multi-cycle accept, return on commit or flush
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (op_mul || op_acc)) state_next = MUL;
                else if (accept && op_div)        state_next = DIV;
            end
            default: begin
                if (flush || count == '0) state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, iterate, and write HI/LO on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div0     <= 1'b0;
            err_op   <= 1'b0;
            count    <= '0;
            prod     <= '0;
            rem      <= '0;
            quot     <= '0;
            dvsr     <= '0;
            raw_a    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
`ifdef MDU_ACCUM_EN
            acc_en   <= 1'b0;
            acc_sub  <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            div0   <= 1'b0;
            err_op <= 1'b0;
            if (accept) begin
                if (op_mthi) hi <= src_a;
                if (op_mtlo) lo <= src_a;
                if (op_illegal) err_op <= 1'b1;
                if (op_mul || op_acc) begin
                    prod  <= product;
                    count <= CW'(MUL_LAT - 1);
`ifdef MDU_ACCUM_EN
                    acc_en  <= op_acc;
                    acc_sub <= (req_op == 4'd9) || (req_op == 4'd10);
`endif
                end
                if (op_div) begin
                    rem      <= '0;
                    quot     <= mag_a;
                    dvsr     <= mag_b;
                    raw_a    <= src_a;
                    neg_q    <= sign_a ^ sign_b;
                    neg_r    <= sign_a;
                    div_zero <= (src_b == '0);
                    count    <= CW'(WIDTH);
                end
            end else if (busy && !flush) begin
                if (count != '0) begin
                    count <= count - CW'(1);
                    if (state == DIV) begin
                        if (!diff[WIDTH]) begin
                            rem  <= diff[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= rem_sh[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                    end
                end else if (commit) begin
                    done <= 1'b1;
                    if (state == MUL) begin
                        {hi, lo} <= mul_result;
                    end else if (div_zero) begin
                        hi   <= raw_a;
                        lo   <= '1;
                        div0 <= 1'b1;
                    end else begin
                        lo <= neg_q ? -quot : quot;
                        hi <= neg_r ? -rem : rem;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_beta.sv
// tb_mdu_beta: table-driven vectors, hand-written corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_mdu_beta;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [W-1:0]  src_a, src_b;
    logic          flush;
    logic [W-1:0]  hi, lo;
    logic          busy, done, div0, err_op;

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  mhi = '0;
    logic [W-1:0]  mlo = '0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
        logic         exp_err;
    } vec_t;

    vec_t vecs[13];

    mdu_beta #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0), .err_op(err_op)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int latOf(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return LAT;
            4'd3, 4'd4: return W + 1;
`ifdef MDU_ACCUM_EN
            4'd7, 4'd8, 4'd9, 4'd10: return LAT;
`endif
            default: return 0;
        endcase
    endfunction

    // Reference behaviour written straight from the arithmetic rules
    function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] h0, input logic [W-1:0] l0,
                                     output logic [W-1:0] h, output logic [W-1:0] l,
                                     output logic dz, output logic err);
        int          sa, sb;
        longint      sp;
        logic [63:0] p, acc;
        h = h0; l = l0; dz = 1'b0; err = 1'b0;
        sa = a; sb = b;
        case (op)
            4'd0: begin end
            4'd1: begin sp = longint'(sa) * longint'(sb); {h, l} = sp; end
            4'd2: begin p = 64'(a) * 64'(b); {h, l} = p; end
            4'd3, 4'd4: begin
                if (b == 0) begin
                    h = a; l = '1; dz = 1'b1;
                end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 0;
                end else if (op == 4'd3) begin
                    l = sa / sb; h = sa % sb;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            4'd5: h = a;
            4'd6: l = a;
`ifdef MDU_ACCUM_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd7 || op == 4'd9) begin
                    sp = longint'(sa) * longint'(sb); p = sp;
                end else begin
                    p = 64'(a) * 64'(b);
                end
                acc = {h0, l0};
                acc = (op >= 4'd9) ? acc - p : acc + p;
                {h, l} = acc;
            end
`endif
            default: err = 1'b1;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issue_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = 4'd0;
    endtask

    task automatic execOp(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz, input logic eerr,
                          input int lat);
        int window_bad = 0;
        applyStimulus(op, a, b);
        if (lat == 0) begin
            @(negedge clk);
            checkOutput({name, "_err"}, 64'(err_op), 64'(eerr));
            checkOutput({name, "_busy"}, 64'(busy), 64'd0);
            checkOutput({name, "_done"}, 64'(done), 64'd0);
            checkOutput({name, "_hi"}, 64'(hi), 64'(eh));
            checkOutput({name, "_lo"}, 64'(lo), 64'(el));
            @(negedge clk);
            checkOutput({name, "_err_clr"}, 64'(err_op), 64'd0);
        end else begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0 || hi !== mhi || lo !== mlo)
                    window_bad++;
            end
            checkOutput({name, "_window"}, 64'(window_bad), 64'd0);
            @(negedge clk);
            checkOutput({name, "_done"}, 64'(done), 64'd1);
            checkOutput({name, "_div0"}, 64'(div0), 64'(edz));
            checkOutput({name, "_ready"}, 64'(req_ready), 64'd1);
            checkOutput({name, "_hi"}, 64'(hi), 64'(eh));
            checkOutput({name, "_lo"}, 64'(lo), 64'(el));
        end
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b, h, l;
        logic         dz, err;
        int           cnt;

        vecs[0]  = '{4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[3]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[4]  = '{4'd4, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{4'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6]  = '{4'd6, 32'hCAFE_F00D, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[7]  = '{4'd4, 32'd7, 32'd3, 32'd1, 32'd2, 1'b0, 1'b0};
        vecs[8]  = '{4'd0, 32'd5, 32'd5, 32'd1, 32'd2, 1'b0, 1'b0};
        vecs[9]  = '{4'd12, 32'd5, 32'd5, 32'd1, 32'd2, 1'b0, 1'b1};
        vecs[10] = '{4'd5, 32'd0, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0};
        vecs[11] = '{4'd6, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
`ifdef MDU_ACCUM_EN
        vecs[12] = '{4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0};
`else
        vecs[12] = '{4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; src_a = '0; src_b = '0; flush = 1'b0;
        #12;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_flags", 64'({busy, done, div0, err_op}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", 64'(req_ready), 64'd1);

        foreach (vecs[i])
            execOp($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, vecs[i].exp_err, latOf(vecs[i].op));

        // Flush a divide in c10 while another request is held valid
        applyStimulus(4'd3, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 4'd1; src_a = 32'd3; src_b = 32'd4;
        #1;
        checkOutput("flush_ready_c10", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0; req_op = 4'd0;
        @(negedge clk);
        checkOutput("flush_ready_c11", 64'(req_ready), 64'd1);
        checkOutput("flush_busy_c11", 64'(busy), 64'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("flush_no_done", 64'(cnt), 64'd0);
        checkOutput("flush_hi", 64'(hi), 64'(mhi));
        checkOutput("flush_lo", 64'(lo), 64'(mlo));

        // Reset asserted in c2 of a multiply
        execOp("pre_rst_hi", 4'd5, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, mlo, 1'b0, 1'b0, 0);
        execOp("pre_rst_lo", 4'd6, 32'h5A5A_5A5A, 32'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 0);
        applyStimulus(4'd1, 32'd9, 32'd9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        checkOutput("midrst_busy_done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        checkOutput("midrst_no_commit", 64'(cnt), 64'd0);
        checkOutput("midrst_hi_after", 64'({hi, lo}), 64'd0);
        mhi = '0; mlo = '0;

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: begin end
            endcase
            refModel(op, a, b, mhi, mlo, h, l, dz, err);
            execOp($sformatf("rnd%0d_op%0d", i, op), op, a, b, h, l, dz, err, latOf(op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_beta.md
# mdu_beta

Parametrised multi-cycle multiply/divide unit with architectural HI/LO, successor to the MDU embedded in the single-issue ALU. It executes signed and unsigned multiply, divide, HI/LO moves and (optionally) multiply-accumulate over a `WIDTH`-bit datapath behind a valid/ready handshake. It supports a configurable multiplier latency, flush-abort, and defined divide-by-zero results. It sits beside the execute-stage ALU; the pipeline stalls on `busy` for MFHI/MFLO and on `~req_ready` for issue.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `MUL_LAT`, 3, multiply latency in cycles, ≥1.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  = idle & ~`flush`.
- `req_op`  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11–15 illegal.
- `src_a`  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- `src_b`  in  WIDTH  multiplier / divisor.
- `flush`  in  1  abort any in-flight operation.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  multi-cycle operation in flight.
- `done`  out  1  one-cycle pulse; new HI/LO visible this cycle.
- `div0`  out  1  pulses with `done` for divide by zero.
- `err_op`  out  1  one-cycle pulse after an illegal op is accepted.

## Operation
- Reset (async, `rst_n`=0): HI=LO=0, state IDLE; `busy`, `done`, `div0`, `err_op` = 0; `req_ready` = 1 once reset is released.
- Accept occurs when `req_valid & req_ready` at a rising edge. NOP is accepted with no effect.
- States: IDLE, MUL, DIV. Transitions:
  - IDLE→MUL on accept of ops 1, 2, 7–10.
  - IDLE→DIV on accept of ops 3, 4.
  - MUL/DIV→IDLE on the commit edge or on `flush`.
- A down-counter is loaded with `MUL_LAT`-1 or `WIDTH`, and commit happens at count 0.
- MTHI/MTLO: write HI or LO with `src_a` on the accept edge. No busy cycle; `done` is not pulsed.
- MULT/MULTU produce the full 2·`WIDTH`-bit product of signed or unsigned operands. HI gets the upper half, LO the lower half. The product is registered at accept and delayed through `MUL_LAT` stages or counter cycles.
- MADD(U)/MSUB(U): {HI,LO} ± product, modulo 2^(2·`WIDTH`). HI/LO are sampled at commit.
- DIV/DIVU use a restoring divider on magnitudes, 1 quotient bit per cycle for `WIDTH` cycles, then 1 sign-fixup cycle.
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - MIN/−1: LO = MIN, HI = 0.
- Divide by zero: HI = `src_a`, LO = all-ones, `div0`=1 with `done`. Latency is unchanged.
- Illegal op: no state change, HI/LO unchanged, `err_op`=1 in the cycle after accept.
- `flush` in any cycle returns to IDLE at the next edge. There is no HI/LO write and no `done`. `flush` wins over a coincident commit. Requests are not accepted while `flush`=1.

## Timing
- Cycle c0 is the accept cycle. Operation latency L is `MUL_LAT` for MUL, or `WIDTH`+1 for DIV.
- `busy`=1 and `req_ready`=0 in cycles c1..cL.
- HI/LO update on the edge ending cL; `done` (and `div0`) are high in cL+1.
- `req_ready`=1 in cL+1, so back-to-back issue is allowed in that cycle.
- HI/LO outputs are registered. During `busy` they hold the pre-operation values.
- `err_op` is registered, high in c1 only.

## Configuration
- `MDU_ACCUM_EN` defined: ops 7–10 execute as described.
- `MDU_ACCUM_EN` undefined: ops 7–10 are treated as illegal (`err_op` pulse, no effect), and the accumulator adder is not instantiated.

## Test plan
All scenarios use `WIDTH`=32 and `MUL_LAT`=3.
- MULT a=0xFFFFFFFF, b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` in c4. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `done` in c34, `busy` high c1..c33. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=100, b=0 → HI=100, LO=0xFFFFFFFF, `div0`=`done`=1 in c34.
- Start DIV, assert `flush` in c10 → no `done`, HI/LO unchanged, `req_ready`=1 in c11. A request held valid in c10 is not accepted.
- With the macro: MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 → HI=1, LO=0 in c4. Without the macro: `err_op`=1 in c1, HI/LO unchanged, `busy` never set.
- Drop `rst_n` mid-MULT (c2) → `hi`, `lo`, `busy`, `done` = 0 immediately, with no commit after release.
